// File: rtl/rcv_pkg.sv
// Shared types and constants for the serial receive path.
package rcv_pkg;

    // Default word width, shared with the byte/packet decoder.
    localparam int RCV_DATA_WIDTH = 8;

    // One-entry holding register occupancy.
    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_t;

endpackage : rcv_pkg

// File: rtl/rcv_bit_counter.sv
// Wrapping bit counter: counts enabled cycles 0..WRAP_VAL, then returns to 0.
// The wrap strobe is combinational and marks the cycle whose count
// completes a word.
module rcv_bit_counter #(
    parameter int               CNT_W    = 3,
    parameter logic [CNT_W-1:0] WRAP_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             count_enable,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);

    // Wrap fires on the enabled cycle that sees the terminal count.
    assign wrap = count_enable && (count == WRAP_VAL);

    // Count register; clear beats count_enable.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state is written with <= so every register
        // samples values from before the edge, regardless of block order.
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_enable) begin
            count <= wrap ? '0 : count + CNT_W'(1);
        end
    end

endmodule : rcv_bit_counter

// File: rtl/rcv_word_assembler.sv
// Serial-to-parallel receive assembler. Shifts accepted bits into a word,
// counts them, and hands completed words to downstream logic through a
// one-entry valid/ready holding register with sticky overrun detection.
module rcv_word_assembler
    import rcv_pkg::*;
#(
    parameter int DATA_WIDTH = RCV_DATA_WIDTH,
    parameter bit LSB_FIRST  = 1'b1,
    parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  shift_enable,
    input  logic                  serial_in,
    input  logic                  bit_skip,
    input  logic                  frame_clear,
    input  logic                  word_ready,
    output logic [DATA_WIDTH-1:0] word_data,
    output logic                  word_valid,
    output logic                  overrun,
    output logic [CNT_W-1:0]      bit_count
);

    logic [DATA_WIDTH-1:0] sr;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  accepted;
    logic                  word_complete;
    hold_state_t           state;
    hold_state_t           state_next;
    logic                  load_word;
    logic                  set_overrun;

    // Stuffed bits and bits arriving with a frame restart are discarded.
    assign accepted = shift_enable && !bit_skip && !frame_clear;

    // Shift result including the current bit; this is also the completed word.
    always_comb begin
        if (LSB_FIRST) begin
            shifted = {serial_in, sr[DATA_WIDTH-1:1]};
        end else begin
            shifted = {sr[DATA_WIDTH-2:0], serial_in};
        end
    end

    rcv_bit_counter #(
        .CNT_W    (CNT_W),
        .WRAP_VAL (CNT_W'(DATA_WIDTH - 1))
    ) u_bit_counter (
        .clk          (clk),
        .rst          (rst),
        .count_enable (accepted),
        .clear        (frame_clear),
        .count        (bit_count),
        .wrap         (word_complete)
    );

    // Partial-word shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (frame_clear) begin
            sr <= '0;
        end else if (accepted) begin
            sr <= shifted;
        end
    end

    // Holding FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HOLD_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Holding FSM next state: decide whether a completed word is loaded,
    // handed off, or dropped as an overrun.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_next  = state;
        load_word   = 1'b0;
        set_overrun = 1'b0;
        if (frame_clear) begin
            state_next = HOLD_EMPTY;
        end else begin
            case (state)
                HOLD_EMPTY: begin
                    if (word_complete) begin
                        load_word  = 1'b1;
                        state_next = HOLD_FULL;
                    end
                end
                HOLD_FULL: begin
                    if (word_complete) begin
                        // Old word leaves on this edge only if accepted now.
                        load_word   = word_ready;
                        set_overrun = !word_ready;
                        state_next  = HOLD_FULL;
                    end else if (word_ready) begin
                        state_next = HOLD_EMPTY;
                    end
                end
                default: state_next = HOLD_EMPTY;
            endcase
        end
    end

    // Holding register: stable unless a new word is loaded or the frame restarts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_data <= '0;
        end else if (frame_clear) begin
            word_data <= '0;
        end else if (load_word) begin
            word_data <= shifted;
        end
    end

    // Sticky overrun flag; only reset or a frame restart clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (frame_clear) begin
            overrun <= 1'b0;
        end else if (set_overrun) begin
            overrun <= 1'b1;
        end
    end

    assign word_valid = (state == HOLD_FULL);

endmodule : rcv_word_assembler

// File: doc/rcv_word_assembler.md
# rcv_word_assembler

Parametrised serial-to-parallel receive assembler for the packet processor datapath. It shifts decoded serial bits into a DATA_WIDTH-bit word and counts bits itself. It discards stuffed bits on request and hands each completed word to the downstream byte/packet logic through a one-entry valid/ready holding register with sticky overrun detection. It replaces the fixed 8-bit, count-less shifter, so downstream logic no longer tracks bit position.

## Interface
Parameters:
- DATA_WIDTH, 8, word width in bits; legal range 2..32.
- LSB_FIRST, 1, bit order. 1: first received bit lands in bit 0 (USB order). 0: first received bit lands in bit DATA_WIDTH-1.
- CNT_W, $clog2(DATA_WIDTH), width of the bit counter. Derived; do not override.

Ports:
- clk, in, 1, system clock; all state updates on rising edge.
- rst, in, 1, asynchronous active-high reset.
- shift_enable, in, 1, single-cycle strobe: serial_in is valid this cycle.
- serial_in, in, 1, decoded serial data bit.
- bit_skip, in, 1, qualifies shift_enable. When 1, the bit is a stuffed bit: discard it, do not shift, do not count.
- frame_clear, in, 1, synchronous restart at frame boundary (EOP/sync detect).
- word_ready, in, 1, downstream accepts word_data this cycle.
- word_data, out, DATA_WIDTH, holding-register contents.
- word_valid, out, 1, holding register is full.
- overrun, out, 1, sticky: a completed word was lost.
- bit_count, out, CNT_W, number of bits in the current partial word (0..DATA_WIDTH-1).

## Operation
- Accepted bit: shift_enable=1 and bit_skip=0 and frame_clear=0.
- Shift rule, per accepted bit:
  - LSB_FIRST=1: sr <= {serial_in, sr[DATA_WIDTH-1:1]}.
  - LSB_FIRST=0: sr <= {sr[DATA_WIDTH-2:0], serial_in}.
- Bit counter:
  - Increments on each accepted bit.
  - When an accepted bit arrives with bit_count==DATA_WIDTH-1, the word completes and the counter wraps to 0.
  - The completed word is the shift result including the current bit.
- Holding FSM, two states:
  - EMPTY to FULL: on word completion; load word_data.
  - FULL to EMPTY: on word_ready=1 with no completion.
  - FULL to FULL on completion with word_ready=1: load new word; valid stays 1; no overrun.
  - FULL on completion with word_ready=0: drop the new word, keep old word_data, set overrun.
  - word_ready while EMPTY is ignored.
- overrun is sticky. Only rst or frame_clear clears it.
- frame_clear has priority over shift_enable and word_ready. It sets sr=0, bit_count=0, overrun=0, state to EMPTY (word_valid=0), and word_data=0.
- bit_skip with shift_enable=0 has no effect.

## Timing
- Reset values: word_data=0, word_valid=0, overrun=0, bit_count=0, internal sr=0.
- Asynchronous reset takes effect mid-word. The partial word and any held word are lost.
- Latency: word_valid and word_data update on the clock edge that samples the final accepted bit. They are visible the cycle after that strobe.
- bit_count is registered and reflects all accepted bits through the previous edge.
- Back-to-back shift_enable on every cycle is supported. A sustained throughput of one word per DATA_WIDTH cycles needs word_ready within DATA_WIDTH-1 cycles of word_valid rising.
- The handshake completes on the edge where word_valid=1 and word_ready=1.
- word_data must stay stable while word_valid=1 and no new word is loaded.

## Structure
- Package rcv_pkg holds:
  - hold_state_t enum (HOLD_EMPTY, HOLD_FULL).
  - Default DATA_WIDTH constant, shared with the byte/packet decoder.
- One sub-module: rcv_bit_counter.
  - Parametrised CNT_W and wrap value.
  - Inputs: count_enable, clear.
  - Outputs: count, wrap strobe.
  - Same rst polarity as this block.
- Shift register, holding register and FSM stay in the top module.

## Test plan
- Reset mid-word: 5 accepted bits, then assert rst. Outputs go to 0 immediately. The next 8 bits yield one clean word.
- LSB_FIRST=1, DATA_WIDTH=8: send bits 1,0,1,1,0,0,1,0. Expect word_data=8'h4D and word_valid=1 one cycle after the 8th strobe. With LSB_FIRST=0, the same bits give 8'hB2.
- Stuffed bit: 8 data bits for 8'hFF with a bit_skip strobe (serial_in=0) after bit 6. Expect word_data=8'hFF, with completion one strobe later than unstuffed.
- Overrun: word_ready held 0 across two full words A5 then 3C. Expect word_data=A5, overrun=1. word_ready then gives word_valid=0 with overrun still 1. frame_clear gives overrun=0.
- Simultaneous: word_ready=1 on the same edge as completion of the second word. Expect word_valid to stay 1, word_data to become the second word, and overrun=0.
- frame_clear at bit_count=3 with word_valid=1: all state clears. The next 8 bits 8'h01 produce exactly one word, 8'h01. Repeat with DATA_WIDTH=16.
